// File: rtl/blockram_pkg.sv
// Shared types and helpers for the true dual-port block RAM.
// Holds the per-port read-mode enum and the byte-lane merge used by both write and read paths.
package blockram_pkg;

  typedef enum logic [1:0] {
    NO_CHANGE   = 2'd0,
    READ_FIRST  = 2'd1,
    WRITE_FIRST = 2'd2
  } read_mode_e;

  // Widest word the merge helper handles; callers cast to and from their own width.
  localparam int MERGE_MAX_W = 512;

  // Returns old_w with every lane whose enable bit is set replaced by new_w.
  function automatic logic [MERGE_MAX_W-1:0] merge_lanes(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] we,
    input int                     bw
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int j = 0; j < MERGE_MAX_W; j++) begin
      if (we[j / bw]) res[j] = new_w[j];
    end
    return res;
  endfunction

endpackage

// File: rtl/blockram_tdp_if.sv
// Signal bundle for both ports of blockram_tdp plus the collision flag.
// The master side drives requests; the slave side (the RAM) returns read data and flags.
interface blockram_tdp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_DEPTH = 1024
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int AW = $clog2(DATA_DEPTH);

  logic                  rsta, ena;
  logic [NB-1:0]         wea;
  logic [AW-1:0]         addra;
  logic [DATA_WIDTH-1:0] dia, doa;
  logic                  vala;

  logic                  rstb, enb;
  logic [NB-1:0]         web;
  logic [AW-1:0]         addrb;
  logic [DATA_WIDTH-1:0] dib, dob;
  logic                  valb;

  logic                  collision;

  modport master (
    output rsta, ena, wea, addra, dia,
    output rstb, enb, web, addrb, dib,
    input  doa, vala, dob, valb, collision
  );

  modport slave (
    input  rsta, ena, wea, addra, dia,
    input  rstb, enb, web, addrb, dib,
    output doa, vala, dob, valb, collision
  );

endinterface

// File: rtl/blockram_port_out.sv
// Read side of one RAM port: mode-dependent read issue, stage-1 register and optional stage-2.
// The raw word arrives from the array before this edge's writes are applied.
module blockram_port_out
  import blockram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter read_mode_e            MODE       = NO_CHANGE,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0,
  localparam int                   NB         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NB-1:0]         we,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  val
);

  logic                  issue;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] q1;
  logic                  v1;
  logic                  r1;

  assign issue = en && !rst && ((MODE != NO_CHANGE) || (we == '0));

  // Only this port's own lanes are forwarded; the other port's same-edge write is never visible.
  assign rd_word = (MODE == WRITE_FIRST)
                 ? DATA_WIDTH'(merge_lanes(MERGE_MAX_W'(mem_q), MERGE_MAX_W'(di),
                                           MERGE_MAX_W'(we), BYTE_WIDTH))
                 : mem_q;

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= INIT_DATA;
      v1 <= 1'b0;
      r1 <= 1'b0;
    end else begin
      v1 <= issue;
      r1 <= en && rst;
      if (en && rst)  q1 <= INIT_DATA;
      else if (issue) q1 <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q2;
    logic                  v2;

    // Stage 2 also follows a synchronous output reset so dout shows INIT_DATA afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q2 <= INIT_DATA;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1 || r1) q2 <= q1;
      end
    end

    assign dout = q2;
    assign val  = v2;
  end else begin : g_no_out_reg
    assign dout = q1;
    assign val  = v1;
  end

endmodule

// File: rtl/blockram_tdp.sv
// True dual-port block RAM with byte-lane write enables and per-port read modes.
// Owns the array, the A-priority write merge and the same-address collision flag.
module blockram_tdp
  import blockram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BYTE_WIDTH  = 8,
  parameter int                    DATA_DEPTH  = 1024,
  parameter read_mode_e            MODE_A      = NO_CHANGE,
  parameter read_mode_e            MODE_B      = NO_CHANGE,
  parameter int                    OUT_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA_A = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA_B = '0,
  parameter string                 INIT_FILE   = ""
) (
  input logic           clk,
  input logic           rst_n,
  blockram_tdp_if.slave bus
);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("blockram_tdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DATA_DEPTH < 2) begin : g_bad_depth
    $error("blockram_tdp: DATA_DEPTH must be at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  initial begin
    for (int i = 0; i < DATA_DEPTH; i++) mem[i] = '0;
  end

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0]            old_w,
    input logic [DATA_WIDTH-1:0]            new_w,
    input logic [DATA_WIDTH/BYTE_WIDTH-1:0] we
  );
    return DATA_WIDTH'(merge_lanes(MERGE_MAX_W'(old_w), MERGE_MAX_W'(new_w),
                                   MERGE_MAX_W'(we), BYTE_WIDTH));
  endfunction

  logic [DATA_WIDTH-1:0] q_a, q_b, word_a, word_b;
  logic                  a_in_range, b_in_range, same_addr;
  logic                  wr_a, wr_b, wr_b_eff;
  logic                  collision_q;

  assign q_a        = mem[bus.addra];
  assign q_b        = mem[bus.addrb];
  assign a_in_range = 32'(bus.addra) < DATA_DEPTH;
  assign b_in_range = 32'(bus.addrb) < DATA_DEPTH;
  assign same_addr  = (bus.addra == bus.addrb);
  assign wr_a       = bus.ena && a_in_range && (bus.wea != '0);
  assign wr_b       = bus.enb && b_in_range && (bus.web != '0);
  // On a shared address port A writes the fully merged word, so port B stands down.
  assign wr_b_eff   = wr_b && !(wr_a && same_addr);

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    word_b = merge_word(q_b, bus.dib, bus.web);
    word_a = merge_word((wr_b && same_addr) ? word_b : q_a, bus.dia, bus.wea);
  end

  // NOTE: the array has no reset; rst_n only touches the control and output registers, so
  // contents survive a reset and the array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_a)     mem[bus.addra] <= word_a;
    if (wr_b_eff) mem[bus.addrb] <= word_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision_q <= 1'b0;
    else        collision_q <= bus.ena && bus.enb && same_addr && a_in_range
                               && ((bus.wea & bus.web) != '0);
  end

  assign bus.collision = collision_q;

  blockram_port_out #(
    .DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH),
    .MODE(MODE_A), .OUT_REG(OUT_REG), .INIT_DATA(INIT_DATA_A)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .rst(bus.rsta), .en(bus.ena), .we(bus.wea),
    .di(bus.dia), .mem_q(q_a), .dout(bus.doa), .val(bus.vala)
  );

  blockram_port_out #(
    .DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH),
    .MODE(MODE_B), .OUT_REG(OUT_REG), .INIT_DATA(INIT_DATA_B)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .rst(bus.rstb), .en(bus.enb), .we(bus.web),
    .di(bus.dib), .mem_q(q_b), .dout(bus.dob), .val(bus.valb)
  );

endmodule
